// File: rtl/addsub_serial_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
interface addsub_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic [WIDTH-1:0] d;
   logic             co;
   logic             ovf;
   logic             busy;
   logic             done;

   modport master (
      output start, mode, a, b, bin,
      input  d, co, ovf, busy, done
   );

   modport slave (
      input  start, mode, a, b, bin,
      output d, co, ovf, busy, done
   );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: one shared DIGIT-bit slice, LSB-first, start/done handshake.
// Optional saturation of d on signed overflow when ADDSUB_SAT_EN is defined.
module addsub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input logic           clk,
   input logic           rst,
   addsub_serial_if.slave bus
);
   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_d;
   logic             r_sub;
   logic             r_carry;
   logic             r_co;
   logic             r_ovf;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept;
   logic             w_last;
   logic [DIGIT-1:0] w_aDig;
   logic [DIGIT-1:0] w_bDig;
   logic [DIGIT-1:0] w_sumDig;
   logic             w_cOut;
   logic [WIDTH-1:0] w_sumNext;
   logic             w_aMsb;
   logic             w_bMsb;
   logic             w_rMsb;
   logic             w_ovf;
   logic             w_co;
   logic [WIDTH-1:0] w_dNext;

   assign w_accept = (r_state != RUN) && bus.start;
   assign w_last   = (r_cnt == LAST_DIGIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_nextState = RUN;
         RUN:     if (w_last) w_nextState = DONE;
         DONE:    w_nextState = bus.start ? RUN : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (r_state == RUN);
      bus.done = (r_state == DONE);
      bus.d    = r_d;
      bus.co   = r_co;
      bus.ovf  = r_ovf;
   end

   // Operands shift right one digit per cycle, so the slice always sees bit 0 upward;
   // on the last digit, bit DIGIT-1 of each operand register is the original MSB.
   always_comb begin
      w_aDig = r_a[DIGIT-1:0];
      w_bDig = r_sub ? ~r_b[DIGIT-1:0] : r_b[DIGIT-1:0];
      {w_cOut, w_sumDig} = {1'b0, w_aDig} + {1'b0, w_bDig} + {{DIGIT{1'b0}}, r_carry};
      w_sumNext = (r_sum >> DIGIT) | (WIDTH'(w_sumDig) << (WIDTH - DIGIT));
      w_aMsb    = r_a[DIGIT-1];
      w_bMsb    = r_b[DIGIT-1];
      w_rMsb    = w_sumNext[WIDTH-1];
      w_ovf     = r_sub ? ((w_aMsb != w_bMsb) && (w_rMsb != w_aMsb))
                        : ((w_aMsb == w_bMsb) && (w_rMsb != w_aMsb));
      w_co      = r_sub ? ~w_cOut : w_cOut;
   end

`ifdef ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   always_comb begin
      w_dNext = w_sumNext;
      if (w_ovf) w_dNext = w_aMsb ? MIN_NEG : MAX_POS;
   end
`else
   assign w_dNext = w_sumNext;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_d     <= '0;
         r_co    <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_sum   <= '0;
         r_sub   <= bus.mode;
         r_carry <= bus.mode ? ~bus.bin : bus.bin;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_a     <= r_a >> DIGIT;
         r_b     <= r_b >> DIGIT;
         r_sum   <= w_sumNext;
         r_carry <= w_cOut;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            r_d   <= w_dNext;
            r_co  <= w_co;
            r_ovf <= w_ovf;
         end
      end
   end
endmodule

// File: tb/tb_addsub_serial.sv
// Randomized and directed bench for addsub_serial (WIDTH=8, DIGIT=2) against a plain-arithmetic model.
module tb_addsub_serial;
   localparam int WIDTH = 8;
   localparam int DIGIT = 2;
   localparam int N     = WIDTH / DIGIT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   cycle    = 0;
   int   lastDone = -100;
   int   firstDone;
   logic [7:0] prevD   = 8'h00;
   logic       prevCo  = 1'b0;
   logic       prevOvf = 1'b0;

   addsub_serial_if #(.WIDTH(WIDTH)) bus ();

   addsub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycle);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Reference: exact integer arithmetic, overflow judged by the true signed result range.
   function automatic void model(input logic m, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                                 output logic [7:0] ed, output logic eco, output logic eovf);
      int ua = int'(av);
      int ub = int'(bv);
      int sa = int'($signed(av));
      int sb = int'($signed(bv));
      int ib = bi ? 1 : 0;
      int ures;
      int sres;
      if (!m) begin
         ures = ua + ub + ib;
         sres = sa + sb + ib;
         eco  = (ures > 255);
      end else begin
         ures = ua - ub - ib;
         sres = sa - sb - ib;
         eco  = (ua < ub + ib);
      end
      eovf = (sres > 127) || (sres < -128);
      ed   = 8'(ures);
`ifdef ADDSUB_SAT_EN
      if (eovf) ed = av[7] ? 8'h80 : 8'h7F;
`endif
   endfunction

   task automatic applyStimulus(input logic m, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                                input bit midStart);
      logic [7:0] ed;
      logic       eco;
      logic       eovf;
      model(m, av, bv, bi, ed, eco, eovf);
      bus.start = 1'b1;
      bus.mode  = m;
      bus.a     = av;
      bus.b     = bv;
      bus.bin   = bi;
      stepCycle();
      bus.start = 1'b0;
      for (int k = 1; k <= N; k++) begin
         bus.a    = 8'($urandom);
         bus.b    = 8'($urandom);
         bus.mode = 1'($urandom);
         bus.bin  = 1'($urandom);
         if (k == 2 && midStart) bus.start = 1'b1;
         checkOutput("busy", 32'(bus.busy), 32'd1);
         checkOutput("doneEarly", 32'(bus.done), 32'd0);
         checkOutput("dHold", 32'(bus.d), 32'(prevD));
         checkOutput("coHold", 32'(bus.co), 32'(prevCo));
         checkOutput("ovfHold", 32'(bus.ovf), 32'(prevOvf));
         stepCycle();
         bus.start = 1'b0;
      end
      checkOutput("done", 32'(bus.done), 32'd1);
      checkOutput("busyAtDone", 32'(bus.busy), 32'd0);
      checkOutput("d", 32'(bus.d), 32'(ed));
      checkOutput("co", 32'(bus.co), 32'(eco));
      checkOutput("ovf", 32'(bus.ovf), 32'(eovf));
      lastDone = cycle;
      prevD    = ed;
      prevCo   = eco;
      prevOvf  = eovf;
   endtask

   task automatic idleCycle();
      stepCycle();
      checkOutput("idleBusy", 32'(bus.busy), 32'd0);
      checkOutput("idleDone", 32'(bus.done), 32'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.a     = 8'h00;
      bus.b     = 8'h00;
      bus.bin   = 1'b0;
      rst       = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("rstBusy", 32'(bus.busy), 32'd0);
      checkOutput("rstDone", 32'(bus.done), 32'd0);
      checkOutput("rstD", 32'(bus.d), 32'd0);
      checkOutput("rstCo", 32'(bus.co), 32'd0);
      checkOutput("rstOvf", 32'(bus.ovf), 32'd0);

      // Reset and start together: reset must win.
      bus.start = 1'b1;
      stepCycle();
      rst       = 1'b0;
      bus.start = 1'b0;
      checkOutput("rstWinsBusy", 32'(bus.busy), 32'd0);
      idleCycle();

      applyStimulus(1'b1, 8'h35, 8'h12, 1'b0, 1'b0);
      checkOutput("t1_d", 32'(bus.d), 32'h23);
      checkOutput("t1_co", 32'(bus.co), 32'd0);
      checkOutput("t1_ovf", 32'(bus.ovf), 32'd0);
      idleCycle();

      applyStimulus(1'b1, 8'h05, 8'h07, 1'b1, 1'b0);
      checkOutput("t2_d", 32'(bus.d), 32'hFD);
      checkOutput("t2_co", 32'(bus.co), 32'd1);
      checkOutput("t2_ovf", 32'(bus.ovf), 32'd0);
      idleCycle();

      applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
      checkOutput("t3_d", 32'(bus.d), 32'h7F);
`else
      checkOutput("t3_d", 32'(bus.d), 32'h80);
`endif
      checkOutput("t3_co", 32'(bus.co), 32'd0);
      checkOutput("t3_ovf", 32'(bus.ovf), 32'd1);
      idleCycle();

      applyStimulus(1'b1, 8'h80, 8'h01, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
      checkOutput("t4a_d", 32'(bus.d), 32'h80);
`else
      checkOutput("t4a_d", 32'(bus.d), 32'h7F);
`endif
      checkOutput("t4a_co", 32'(bus.co), 32'd0);
      checkOutput("t4a_ovf", 32'(bus.ovf), 32'd1);
      idleCycle();

      applyStimulus(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0);
      checkOutput("t4b_d", 32'(bus.d), 32'h01);
      checkOutput("t4b_co", 32'(bus.co), 32'd1);
      checkOutput("t4b_ovf", 32'(bus.ovf), 32'd0);
      idleCycle();

      // Mid-run start is ignored; start held in the DONE cycle chains the next operation.
      applyStimulus(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
      checkOutput("t5_d", 32'(bus.d), 32'h46);
      firstDone = lastDone;
      applyStimulus(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
      checkOutput("t5_gap", 32'(lastDone - firstDone), 32'(N + 1));
      checkOutput("t5_d2", 32'(bus.d), 32'hF0);
      idleCycle();

      // Reset asserted in RUN cycle 2 aborts the operation.
      bus.start = 1'b1;
      bus.mode  = 1'b0;
      bus.a     = 8'h55;
      bus.b     = 8'h22;
      bus.bin   = 1'b0;
      stepCycle();
      bus.start = 1'b0;
      stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("t6_busy", 32'(bus.busy), 32'd0);
      checkOutput("t6_d", 32'(bus.d), 32'd0);
      checkOutput("t6_co", 32'(bus.co), 32'd0);
      checkOutput("t6_ovf", 32'(bus.ovf), 32'd0);
      for (int i = 0; i < 2 * N; i++) begin
         stepCycle();
         checkOutput("t6_noDone", 32'(bus.done), 32'd0);
      end
      prevD   = 8'h00;
      prevCo  = 1'b0;
      prevOvf = 1'b0;
      applyStimulus(1'b0, 8'h55, 8'h22, 1'b0, 1'b0);
      checkOutput("t6_fresh", 32'(bus.d), 32'h77);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idleCycle();
      end
      idleCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle digit-serial adder/subtractor.
- Successor to the fixed 4-bit ripple subtractor. Adds:
  - a parametrised width;
  - DIGIT bits processed per clock, LSB first;
  - an add/subtract mode select;
  - a true carry/borrow input, a signed-overflow flag and a start/done handshake.
- Sits in arithmetic datapaths where area matters more than latency. It shares one DIGIT-bit full-adder slice across all digits.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DIGIT, 2, bits processed per cycle. Must be ≥1 and must divide WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- mode  input  1  0 = add (a+b+bin), 1 = subtract (a-b-bin).
- a  input  WIDTH  first operand; captured on accepted start.
- b  input  WIDTH  second operand; captured on accepted start.
- bin  input  1  carry-in (add) or borrow-in (sub); captured on accepted start.
- d  output  WIDTH  result; registered.
- co  output  1  add: carry-out; sub: borrow-out (1 = a < b+bin, unsigned).
- ovf  output  1  signed (two's-complement) overflow of the operation.
- busy  output  1  high while digits are being processed.
- done  output  1  single-cycle pulse; d/co/ovf are valid from this cycle.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state=IDLE, d=0, co=0, ovf=0, busy=0, done=0. Internal operand registers, digit counter and carry are cleared.
- Let N = WIDTH/DIGIT.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- Transitions:
  - IDLE, start=1: capture a, b, mode, bin → RUN, digit counter=0.
  - RUN: process one digit per edge. After the Nth digit → DONE.
  - DONE: start=1 captures a new operation → RUN (back-to-back allowed). Otherwise → IDLE.
- Timing:
  - start is high in cycle 0 → busy high in cycles 1..N → done high in cycle N+1.
  - DIGIT=WIDTH gives N=1, so done arrives 2 cycles after start.
- Arithmetic:
  - Subtract is implemented as a + ~b + ~bin, computed LSB-first through the shared slice.
  - The internal carry register holds the inter-digit carry.
  - Add: co = final carry.
  - Subtract: co = inverted final carry, i.e. the borrow.
- Overflow:
  - Add: ovf=1 when a[MSB]==b[MSB] and d[MSB]!=a[MSB].
  - Subtract: ovf=1 when a[MSB]!=b[MSB] and d[MSB]!=a[MSB].
- Output holding:
  - d, co and ovf update only on the edge into DONE.
  - They hold their value until the next DONE or reset. They never show partial results.
- Operand isolation:
  - start while busy=1 is ignored.
  - a, b, mode and bin changing during RUN have no effect; captured copies are used.
- Reset mid-operation (any state): next cycle state=IDLE, all outputs at reset values, no done pulse. The aborted result is discarded.
- Simultaneous rst and start: rst wins; start is not accepted.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when ovf=1, d saturates instead of wrapping.
  - a[MSB]=0: d = 0111…1 (max positive).
  - a[MSB]=1: d = 1000…0 (min negative).
  - ovf and co still report the unsaturated operation. Latency is unchanged.
- Undefined: d is the wrapped modulo-2^WIDTH result. No saturation logic is present.

Test Plan (WIDTH=8, DIGIT=2, N=4):
1. Basic subtract and latency: mode=1, a=0x35, b=0x12, bin=0, start in cycle 0 → busy cycles 1-4, done only in cycle 5. d=0x23, co=0, ovf=0.
2. Borrow in and out: mode=1, a=0x05, b=0x07, bin=1 → d=0xFD, co=1, ovf=0.
3. Add overflow: mode=0, a=0x7F, b=0x01, bin=0 → co=0, ovf=1. d=0x80 without ADDSUB_SAT_EN; d=0x7F with it.
4. Subtract overflow and carry chain:
   - mode=1, a=0x80, b=0x01, bin=0 → co=0, ovf=1. d=0x7F without ADDSUB_SAT_EN; d=0x80 with it.
   - mode=0, a=0xFF, b=0x01, bin=1 → d=0x01, co=1, ovf=0.
5. Handshake:
   - start pulsed in cycle 2 of RUN with different operands → ignored; result from the original operands.
   - start held high in the DONE cycle → new operation accepted, busy in the next cycle. Second done arrives 5 cycles after the first.
6. Reset mid-operation: rst=1 in cycle 2 of RUN → next cycle busy=0, d=0, co=0, ovf=0. No done ever appears. A fresh start afterwards completes normally.
